// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / branch / memory-wait hazard controller with watchdog (optional HAZARD_PERF_CNT_EN)
module hazard_stall_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs1,
  input  logic             if_id_uses_rs2,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_rd,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             mem_wait_active,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_TO_HIT = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              freeze;
  logic              load_use;
  logic              stall_win;
  logic              flush_win;

  // Hazard detection terms
  assign freeze   = dmem_req & ~dmem_ready;
  assign load_use = id_ex_MemRead & (id_ex_rd != 5'd0) &
                    (((id_ex_rd == if_id_rs1) & if_id_uses_rs1) |
                     ((id_ex_rd == if_id_rs2) & if_id_uses_rs2));

  // Priority resolution: freeze > branch flush > load-use stall > free-run; reset forces free-run
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    stall_win    = 1'b0;
    flush_win    = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        // EX is held, so a pending branch is re-presented once memory completes
        pipe_freeze = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (branch_taken) begin
        // The dependent instruction is squashed, so no load-use stall is needed
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_win   = 1'b1;
      end else if (load_use) begin
        // One bubble clears MemRead in ID/EX, so this self-releases next cycle
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        stall_win    = 1'b1;
      end
    end
  end

  // Next-state logic for the memory-wait tracker
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (freeze)  state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (!freeze) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  assign mem_wait_active = (state_q == ST_MEM_WAIT);

  // Consecutive-freeze counter and sticky watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      mem_timeout <= 1'b0;
    end else if (freeze) begin
      if (wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + WAIT_ONE;
      if (wait_cnt_q == WAIT_TO_HIT) mem_timeout <= 1'b1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] memwait_cnt_q;

  // Saturating performance counters keyed on the winning hazard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      if (stall_win && stall_cnt_q != CNT_MAX)   stall_cnt_q   <= stall_cnt_q + CNT_ONE;
      if (flush_win && flush_cnt_q != CNT_MAX)   flush_cnt_q   <= flush_cnt_q + CNT_ONE;
      if (freeze && memwait_cnt_q != CNT_MAX)    memwait_cnt_q <= memwait_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign memwait_cnt = memwait_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = stall_win ^ flush_win;
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
  assign memwait_cnt = '0;
`endif

endmodule
